sensor_conditioner: RTL

- Upstream front-end for the two-sensor water-pump controller.
- Takes the raw, asynchronous, bouncy level-sensor contacts (lower I, upper S) and synchronises and debounces them.
- Checks the pair for physical plausibility and delivers clean I/S levels plus a sticky fault flag.
- The pump controller consumes I and S directly. When a fault is latched, both outputs are forced to the safe "tank full" code so the pump stops.

---
 rtl/pump_pkg.sv | 16 +
 rtl/sensor_debounce.sv | 50 +++++
 rtl/sensor_conditioner.sv | 111 +++++++++++
 3 files changed

// File: rtl/pump_pkg.sv
// Shared definitions for the pump sensor front-end: fault FSM encoding and safe output code.
// No logic; no latency.
// No flow control; the constants are used directly by the conditioner.
package pump_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } fault_state_t;

    // "Tank full" code: the pump controller stops when it sees both sensors wet.
    localparam logic SAFE_I = 1'b1;
    localparam logic SAFE_S = 1'b1;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus consecutive-cycle debounce for one sensor channel.
// Latency: a clean step appears on level 2+DEBOUNCE_CYCLES edges after it is first sampled.
// No backpressure; level_next exposes the value level takes on the coming edge.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic level_next
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // A differing synced level must hold for DEBOUNCE_CYCLES edges; any return to the old level restarts the count.
    always_comb begin
        level_next = level;
        cnt_next   = '0;
        if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
                level_next = sync2;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    // Synchroniser stages, debounce counter and accepted level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            cnt   <= cnt_next;
            level <= level_next;
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions the I/S level sensors: sync + debounce, plausibility check, sticky fault, safe output forcing.
// Latency: 2+DEBOUNCE_CYCLES edges raw-to-output; outputs are registered with no extra stage.
// No backpressure; outputs are levels consumed every cycle by the pump controller.
module sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FAULT_CYCLES    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic I_raw,
    input  logic S_raw,
    input  logic clear_fault,
    output logic I,
    output logic S,
    output logic fault
);

    import pump_pkg::*;

    localparam logic [7:0] FCNT_LAST = 8'(FAULT_CYCLES - 1);

    logic         i_db;
    logic         i_db_next;
    logic         s_db;
    logic         s_db_next;
    logic         implausible;
    fault_state_t state;
    fault_state_t state_next;
    logic [7:0]   fcnt;
    logic [7:0]   fcnt_next;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_i (
        .clk        (clk),
        .reset      (reset),
        .raw        (I_raw),
        .level      (i_db),
        .level_next (i_db_next)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_s (
        .clk        (clk),
        .reset      (reset),
        .raw        (S_raw),
        .level      (s_db),
        .level_next (s_db_next)
    );

    // Upper sensor wet while the lower one is dry cannot happen physically.
    assign implausible = s_db & ~i_db;

    // Fault FSM next state, evaluated on the debounced pair as it stands before the edge.
    always_comb begin
        state_next = state;
        fcnt_next  = fcnt;
        case (state)
            ST_OK: begin
                if (implausible) begin
                    if (FAULT_CYCLES == 1) begin
                        state_next = ST_FAULT;
                    end else begin
                        state_next = ST_SUSPECT;
                        fcnt_next  = 8'd1;
                    end
                end
            end
            ST_SUSPECT: begin
                if (!implausible) begin
                    state_next = ST_OK;
                    fcnt_next  = 8'd0;
                end else if (fcnt == FCNT_LAST) begin
                    state_next = ST_FAULT;
                end else begin
                    fcnt_next = fcnt + 8'd1;
                end
            end
            ST_FAULT: begin
                if (clear_fault && !implausible) begin
                    state_next = ST_OK;
                    fcnt_next  = 8'd0;
                end
            end
            default: begin
                state_next = ST_OK;
                fcnt_next  = 8'd0;
            end
        endcase
    end

    // State register and output mux; outputs load from next-state values so they track without extra delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_OK;
            fcnt  <= 8'd0;
            I     <= 1'b0;
            S     <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= state_next;
            fcnt  <= fcnt_next;
            if (state_next == ST_FAULT) begin
                I <= SAFE_I;
                S <= SAFE_S;
            end else begin
                I <= i_db_next;
                S <= s_db_next;
            end
            fault <= (state_next == ST_FAULT);
        end
    end

endmodule
